// File: rtl/counter_if.sv
// Counter control/status bundle.
// Master drives controls; slave returns count and flags.
interface counter_if #(
  parameter int WIDTH = 5
);
  logic             clr;
  logic             load;
  logic             enab;
  logic             up_dn;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cnt_out;
  logic             tc;
  logic             ovf;
  logic             ovf_sticky;

  modport master (
    output clr, load, enab, up_dn, step, cnt_in,
    input  cnt_out, tc, ovf, ovf_sticky
  );

  modport slave (
    input  clr, load, enab, up_dn, step, cnt_in,
    output cnt_out, tc, ovf, ovf_sticky
  );
endinterface

// File: rtl/counter_mod.sv
// Modulo up/down counter with programmable step,
// wrap or saturate at bounds, and overflow flags.
module counter_mod #(
  parameter int WIDTH    = 5,
  parameter int MOD_MAX  = (1 << WIDTH) - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_MAX);
  localparam logic [WIDTH:0]   MODN = (WIDTH+1)'(MOD_MAX + 1);

  logic [WIDTH-1:0] cnt;
  logic             ovf_q;
  logic             sticky;

  logic [WIDTH:0]   stp;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   cur;
  logic [WIDTH-1:0] nxt;
  logic             wrap;
  logic [WIDTH-1:0] ld_val;

  // Oversized steps fold into the legal range first
  assign stp    = {1'b0, bus.step} % MODN;
  assign cur    = {1'b0, cnt};
  assign sum    = cur + stp;
  assign ld_val = (bus.cnt_in > MAXV) ? MAXV : bus.cnt_in;

  always_comb begin
    nxt  = cnt;
    wrap = 1'b0;
    if (bus.up_dn) begin
      if (sum > {1'b0, MAXV}) begin
        wrap = 1'b1;
        if (SATURATE) nxt = MAXV;
        else          nxt = WIDTH'(sum - MODN);
      end else begin
        nxt = WIDTH'(sum);
      end
    end else begin
      if (stp > cur) begin
        wrap = 1'b1;
        if (SATURATE) nxt = '0;
        else          nxt = WIDTH'(cur + MODN - stp);
      end else begin
        nxt = WIDTH'(cur - stp);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      ovf_q  <= 1'b0;
      sticky <= 1'b0;
    end else if (bus.clr) begin
      cnt    <= '0;
      ovf_q  <= 1'b0;
      sticky <= 1'b0;
    end else if (bus.load) begin
      cnt    <= ld_val;
      ovf_q  <= 1'b0;
    end else if (bus.enab) begin
      cnt    <= nxt;
      ovf_q  <= wrap;
      sticky <= sticky | wrap;
    end else begin
      ovf_q  <= 1'b0;
    end
  end

  assign bus.cnt_out    = cnt;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky;
  assign bus.tc         = bus.up_dn ? (cnt == MAXV)
                                    : (cnt == '0);
endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: wrap (23),
// saturate (23) and full-range (31) variants.
module tb_counter_mod;
  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  counter_if #(.WIDTH(5)) b0 ();
  counter_if #(.WIDTH(5)) b1 ();
  counter_if #(.WIDTH(5)) b2 ();

  counter_mod #(.WIDTH(5), .MOD_MAX(23), .SATURATE(1'b0))
    u_wrap (.clk(clk), .rst(rst), .bus(b0));
  counter_mod #(.WIDTH(5), .MOD_MAX(23), .SATURATE(1'b1))
    u_sat  (.clk(clk), .rst(rst), .bus(b1));
  counter_mod #(.WIDTH(5), .MOD_MAX(31), .SATURATE(1'b0))
    u_full (.clk(clk), .rst(rst), .bus(b2));

  assign b1.clr    = b0.clr;
  assign b1.load   = b0.load;
  assign b1.enab   = b0.enab;
  assign b1.up_dn  = b0.up_dn;
  assign b1.step   = b0.step;
  assign b1.cnt_in = b0.cnt_in;
  assign b2.clr    = b0.clr;
  assign b2.load   = b0.load;
  assign b2.enab   = b0.enab;
  assign b2.up_dn  = b0.up_dn;
  assign b2.step   = b0.step;
  assign b2.cnt_in = b0.cnt_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l,
                       input logic e, input logic u,
                       input int s, input int ci);
    b0.clr    = c;
    b0.load   = l;
    b0.enab   = e;
    b0.up_dn  = u;
    b0.step   = 5'(s);
    b0.cnt_in = 5'(ci);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    #3 rst = 1'b0;
    #1;
    check("rst_cnt", b0.cnt_out, 0);
    check("rst_ovf", b0.ovf, 0);
    check("rst_sticky", b0.ovf_sticky, 0);
    rst = 1'b1;

    // wrap up through MOD_MAX
    drive(0, 1, 0, 1, 0, 20);
    tick();
    check("ld20", b0.cnt_out, 20);
    drive(0, 0, 1, 1, 3, 0);
    tick();
    check("up_23", b0.cnt_out, 23);
    check("up_23_tc", b0.tc, 1);
    check("up_23_ovf", b0.ovf, 0);
    tick();
    check("wrap_2", b0.cnt_out, 2);
    check("wrap_ovf", b0.ovf, 1);
    check("wrap_sticky", b0.ovf_sticky, 1);
    check("sat_hold23", b1.cnt_out, 23);
    check("sat_ovf", b1.ovf, 1);
    check("full_26", b2.cnt_out, 26);
    check("full_ovf0", b2.ovf, 0);

    // async reset mid-cycle
    #2 rst = 1'b0;
    #1;
    check("arst_cnt", b0.cnt_out, 0);
    check("arst_ovf", b0.ovf, 0);
    check("arst_sticky", b0.ovf_sticky, 0);
    rst = 1'b1;

    // wrap downward, then clr beats load
    drive(0, 1, 0, 0, 0, 1);
    tick();
    check("ld1", b0.cnt_out, 1);
    drive(0, 0, 1, 0, 4, 0);
    tick();
    check("dn_21", b0.cnt_out, 21);
    check("dn_ovf", b0.ovf, 1);
    drive(1, 1, 0, 0, 0, 9);
    tick();
    check("clr_cnt", b0.cnt_out, 0);
    check("clr_sticky", b0.ovf_sticky, 0);
    check("clr_tc_dn", b0.tc, 1);

    // saturating variant
    drive(0, 1, 0, 1, 0, 22);
    tick();
    check("sat_ld22", b1.cnt_out, 22);
    drive(0, 0, 1, 1, 5, 0);
    tick();
    check("sat_up23", b1.cnt_out, 23);
    check("sat_up_ovf", b1.ovf, 1);
    check("wrap_up3", b0.cnt_out, 3);
    tick();
    check("sat_again", b1.cnt_out, 23);
    check("sat_again_ovf", b1.ovf, 1);
    check("wrap_up8", b0.cnt_out, 8);
    check("wrap_up8_ovf", b0.ovf, 0);
    drive(0, 1, 0, 1, 0, 3);
    tick();
    check("sat_ld3", b1.cnt_out, 3);
    check("sat_ld_ovf", b1.ovf, 0);
    check("sat_ld_sticky", b1.ovf_sticky, 1);
    drive(0, 0, 1, 0, 30, 0);
    tick();
    check("sat_dn0", b1.cnt_out, 0);
    check("sat_dn_ovf", b1.ovf, 1);
    check("wrap_step30", b0.cnt_out, 21);
    check("full_step30", b2.cnt_out, 5);

    // clamped load and zero step
    drive(0, 1, 0, 1, 0, 31);
    tick();
    check("clamp23", b0.cnt_out, 23);
    check("clamp_sat", b1.cnt_out, 23);
    check("full_ld31", b2.cnt_out, 31);
    drive(0, 0, 1, 1, 0, 0);
    tick();
    check("step0_cnt", b0.cnt_out, 23);
    check("step0_ovf", b0.ovf, 0);
    check("step0_tc", b0.tc, 1);

    // full-range wrap both ways
    drive(0, 0, 1, 1, 1, 0);
    tick();
    check("full_up0", b2.cnt_out, 0);
    check("full_up_ovf", b2.ovf, 1);
    drive(0, 0, 1, 0, 1, 0);
    tick();
    check("full_dn31", b2.cnt_out, 31);
    check("full_dn_ovf", b2.ovf, 1);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    check("hold31", b2.cnt_out, 31);
    check("hold_ovf", b2.ovf, 0);
    check("hold_sticky", b2.ovf_sticky, 1);
    check("hold_tc_dn", b2.tc, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
